// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of one single-port RAM between requesters A and B; one access issued per cycle.
// Ack and RAM strobe land 1 cycle after grant, rvalid RD_LAT cycles later; a requester waits (req held) until acked.
module ram_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data
);

  logic              elig_a, elig_b, grant_a, grant_b;
  logic              ram_en_d, ram_en_q;
  logic              ram_we_d, ram_we_q;
  logic [ADDR_W-1:0] ram_addr_d, ram_addr_q;
  logic [DATA_W-1:0] ram_wr_data_d, ram_wr_data_q;
  logic              a_ack_d, a_ack_q;
  logic              b_ack_d, b_ack_q;
  logic              last_b_d, last_b_q;
  logic [RD_LAT-1:0] rd_vld_d, rd_vld_q;
  logic [RD_LAT-1:0] rd_own_b_d, rd_own_b_q;

  always_comb begin
    elig_a  = a_req & ~a_ack_q;
    elig_b  = b_req & ~b_ack_q;
    grant_a = elig_a & (~elig_b | last_b_q);
    grant_b = elig_b & ~grant_a;

    ram_en_d      = grant_a | grant_b;
    ram_we_d      = (grant_a & a_we) | (grant_b & b_we);
    ram_addr_d    = ram_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    if (grant_a) begin
      ram_addr_d    = a_addr;
      ram_wr_data_d = a_wdata;
    end else if (grant_b) begin
      ram_addr_d    = b_addr;
      ram_wr_data_d = b_wdata;
    end
    a_ack_d  = grant_a;
    b_ack_d  = grant_b;
    last_b_d = last_b_q;
    if (grant_a) last_b_d = 1'b0;
    if (grant_b) last_b_d = 1'b1;

    // While an issue is on the RAM pins, last_b_q names its owner.
    rd_vld_d[0]   = ram_en_q & ~ram_we_q;
    rd_own_b_d[0] = last_b_q;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_vld_d[i]   = rd_vld_q[i-1];
      rd_own_b_d[i] = rd_own_b_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wr_data_q <= '0;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      last_b_q      <= 1'b1;
      rd_vld_q      <= '0;
      rd_own_b_q    <= '0;
    end else begin
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      a_ack_q       <= a_ack_d;
      b_ack_q       <= b_ack_d;
      last_b_q      <= last_b_d;
      rd_vld_q      <= rd_vld_d;
      rd_own_b_q    <= rd_own_b_d;
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wr_data = ram_wr_data_q;
  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign a_rvalid    = rd_vld_q[RD_LAT-1] & ~rd_own_b_q[RD_LAT-1];
  assign b_rvalid    = rd_vld_q[RD_LAT-1] &  rd_own_b_q[RD_LAT-1];
  assign a_rdata     = ram_rd_data;
  assign b_rdata     = ram_rd_data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Drives three arbiters (RD_LAT 1,2,3) with identical traffic, each backed by its own RAM,
// and checks every cycle against a transaction-level model of grants, memory and read returns.
module tb_ram_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic a_req, a_we, b_req, b_we;
  logic [4:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;

  logic [2:0] ram_en_w, ram_we_w, a_ack_w, b_ack_w, a_rvalid_w, b_rvalid_w;
  logic [2:0][4:0] ram_addr_w;
  logic [2:0][7:0] ram_wr_data_w, ram_rd_data_w, a_rdata_w, b_rdata_w;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int lat;
  logic mix_en = 1'b0;
  int mix_a_cnt = 0;
  int mix_b_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [7:0] mem [32];
    logic [7:0] pipe [3];

    ram_port_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(g + 1)) u_dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack_w[g]), .a_rvalid(a_rvalid_w[g]), .a_rdata(a_rdata_w[g]),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack_w[g]), .b_rvalid(b_rvalid_w[g]), .b_rdata(b_rdata_w[g]),
      .ram_en(ram_en_w[g]), .ram_we(ram_we_w[g]), .ram_addr(ram_addr_w[g]),
      .ram_wr_data(ram_wr_data_w[g]), .ram_rd_data(ram_rd_data_w[g])
    );

    // Block RAM stand-in: douta appears g+1 clocks after the sampling edge.
    always @(posedge clk) begin
      if (ram_en_w[g]) begin
        if (ram_we_w[g]) mem[ram_addr_w[g]] <= ram_wr_data_w[g];
        else             pipe[0] <= mem[ram_addr_w[g]];
      end
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign ram_rd_data_w[g] = pipe[g];
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s [%0d] at cycle %0d: got %0h, expected %0h", nm, idx, cyc, act, exp);
    end
  endtask

  // Transaction-level reference: who owns the RAM each cycle, memory contents, and due reads.
  typedef struct {
    int         due;
    bit         own_b;
    logic [7:0] data;
  } rd_t;

  rd_t        pend [3][$];
  logic [7:0] mem_m [32];
  logic       exp_en = 1'b0, exp_we = 1'b0, exp_a_ack = 1'b0, exp_b_ack = 1'b0;
  logic       exp_own_b = 1'b0, last_b = 1'b1;
  logic [4:0] exp_addr = '0;
  logic [7:0] exp_wdata = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_en = 0; exp_we = 0; exp_a_ack = 0; exp_b_ack = 0;
        exp_addr = '0; exp_wdata = '0; last_b = 1'b1;
        for (int g = 0; g < 3; g++) pend[g].delete();
      end
      for (int g = 0; g < 3; g++) begin
        logic ar, br;
        logic [7:0] rd;
        ar = 0; br = 0; rd = '0;
        if (pend[g].size() > 0 && pend[g][0].due == cyc) begin
          rd_t r;
          r = pend[g].pop_front();
          ar = !r.own_b; br = r.own_b; rd = r.data;
        end
        chk("ram_en", g, 32'(ram_en_w[g]), 32'(exp_en));
        chk("ram_we", g, 32'(ram_we_w[g]), 32'(exp_we));
        chk("ram_addr", g, 32'(ram_addr_w[g]), 32'(exp_addr));
        chk("ram_wr_data", g, 32'(ram_wr_data_w[g]), 32'(exp_wdata));
        chk("a_ack", g, 32'(a_ack_w[g]), 32'(exp_a_ack));
        chk("b_ack", g, 32'(b_ack_w[g]), 32'(exp_b_ack));
        chk("a_rvalid", g, 32'(a_rvalid_w[g]), 32'(ar));
        chk("b_rvalid", g, 32'(b_rvalid_w[g]), 32'(br));
        if (ar) chk("a_rdata", g, 32'(a_rdata_w[g]), 32'(rd));
        if (br) chk("b_rdata", g, 32'(b_rdata_w[g]), 32'(rd));
      end
      if (mix_en) begin
        if (b_rvalid_w[0]) begin
          chk("mix_order_data", mix_b_cnt, 32'(b_rdata_w[0]), 32'(8'(mix_b_cnt) ^ 8'hA5));
          mix_b_cnt++;
        end
        if (a_rvalid_w[0]) mix_a_cnt++;
      end
      if (!rst) begin
        logic want_a, want_b, win_b;
        if (exp_en && exp_we) mem_m[exp_addr] = exp_wdata;
        else if (exp_en)
          for (int g = 0; g < 3; g++) pend[g].push_back('{cyc + g + 1, exp_own_b, mem_m[exp_addr]});
        want_a = a_req && !exp_a_ack;
        want_b = b_req && !exp_b_ack;
        win_b  = (want_a && want_b) ? !last_b : want_b;
        exp_a_ack = want_a && !win_b;
        exp_b_ack = want_b && win_b;
        exp_en    = want_a || want_b;
        exp_we    = 1'b0;
        if (exp_en) begin
          exp_own_b = win_b;
          last_b    = win_b;
          exp_we    = win_b ? b_we : a_we;
          exp_addr  = win_b ? b_addr : a_addr;
          exp_wdata = win_b ? b_wdata : a_wdata;
        end
      end
    end
  end

  task automatic issue(input bit sb, input bit we, input logic [4:0] ad, input logic [7:0] wd, output int l);
    if (sb) begin b_req = 1; b_we = we; b_addr = ad; b_wdata = wd; end
    else    begin a_req = 1; a_we = we; a_addr = ad; a_wdata = wd; end
    l = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if ((sb ? b_ack_w[0] : a_ack_w[0]) == 1'b1) begin l = i; break; end
    end
    if (l == 0) chk("ack_timeout", int'(sb), 32'(sb ? b_ack_w[0] : a_ack_w[0]), 32'd1);
    if (sb) b_req = 0; else a_req = 0;
  endtask

  task automatic rnd_req(input bit sb);
    if (sb) begin b_req = 1; b_we = 1'($urandom); b_addr = 5'($urandom_range(0, 7)); b_wdata = 8'($urandom); end
    else    begin a_req = 1; a_we = 1'($urandom); a_addr = 5'($urandom_range(0, 7)); a_wdata = 8'($urandom); end
  endtask

  initial begin
    rst = 1; a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Single write from A, then a read of it from each side on all three latencies.
    issue(0, 1, 5'd5, 8'h3C, lat);
    chk("first_ack_latency", 0, 32'(lat), 32'd1);
    chk("wr_ram_en", 0, 32'(ram_en_w[0]), 32'd1);
    chk("wr_ram_we", 0, 32'(ram_we_w[0]), 32'd1);
    chk("wr_ram_addr", 0, 32'(ram_addr_w[0]), 32'd5);
    chk("wr_ram_data", 0, 32'(ram_wr_data_w[0]), 32'h3C);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      issue(s[0], 0, 5'd5, 8'h00, lat);
      for (int n = 1; n <= 3; n++) begin
        @(posedge clk); #1;
        chk("rd_rvalid_lat", n, 32'(s ? b_rvalid_w : a_rvalid_w), 32'(3'b001 << (n - 1)));
        chk("rd_other_rvalid", n, 32'(s ? a_rvalid_w : b_rvalid_w), 32'd0);
        chk("rd_data", n, 32'(s ? b_rdata_w[n-1] : a_rdata_w[n-1]), 32'h3C);
      end
    end

    // Reset lands while a read is in flight.
    issue(0, 0, 5'd5, 8'h00, lat);
    rst = 1;
    #1;
    chk("rst_ram_en", 0, 32'(ram_en_w), 32'd0);
    chk("rst_ack", 0, 32'({a_ack_w, b_ack_w}), 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_no_rvalid", 0, 32'({a_rvalid_w, b_rvalid_w}), 32'd0);
    end
    rst = 0;
    issue(0, 1, 5'd7, 8'h11, lat);
    chk("post_rst_ack_latency", 0, 32'(lat), 32'd1);

    // Contention straight out of reset: A first, then strict alternation.
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    a_req = 1; a_we = 1; a_addr = 5'd8; a_wdata = 8'h81;
    b_req = 1; b_we = 1; b_addr = 5'd9; b_wdata = 8'h92;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("cont_a_ack", k, 32'(a_ack_w[0]), 32'(k % 2 == 0));
      chk("cont_b_ack", k, 32'(b_ack_w[0]), 32'(k % 2 == 1));
      chk("cont_ram_en", k, 32'(ram_en_w[0]), 32'd1);
    end
    a_req = 0; b_req = 0;
    repeat (3) @(posedge clk);

    // A holds one read for four cycles: two accesses.
    #1 a_req = 1; a_we = 0; a_addr = 5'd5;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk("held_a_ack", k, 32'(a_ack_w[0]), 32'(k == 1 || k == 3));
    end
    a_req = 0;
    repeat (5) @(posedge clk);
    #1;

    // Fill the RAM from A, then read it all back from B.
    for (int i = 0; i < 32; i++) issue(0, 1, 5'(i), 8'(i) ^ 8'hA5, lat);
    mix_en = 1;
    for (int i = 0; i < 32; i++) issue(1, 0, 5'(i), 8'h00, lat);
    repeat (6) @(posedge clk);
    #1 mix_en = 0;
    chk("mix_b_rvalid_count", 0, 32'(mix_b_cnt), 32'd32);
    chk("mix_a_rvalid_count", 0, 32'(mix_a_cnt), 32'd0);

    // Random traffic on both sides with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (rst) rst = 0;
      else if ($urandom_range(0, 299) == 0) rst = 1;
      if (a_req && a_ack_w[0]) begin
        if ($urandom_range(0, 1) == 1) rnd_req(0); else a_req = 0;
      end else if (!a_req && $urandom_range(0, 1) == 1) rnd_req(0);
      if (b_req && b_ack_w[0]) begin
        if ($urandom_range(0, 1) == 1) rnd_req(1); else b_req = 0;
      end else if (!b_req && $urandom_range(0, 1) == 1) rnd_req(1);
    end
    rst = 0; a_req = 0; b_req = 0;
    repeat (10) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Sequences and shares one single-port block RAM between two requesters, A and B. Default RAM geometry is 32 x 8, one enable, one write-enable, read latency 1.
- Round-robin arbitration; each granted access is issued to the RAM as a registered one-cycle strobe.
- Read data is returned to the owning requester with a valid pulse aligned to the RAM read latency.
- Sits between client logic (for example the read/write test sequencer) and the blk_mem_gen instance.

Parameters:
- ADDR_W, 5, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, RAM clocks from the ena/addra sampling edge to valid douta. Legal range 1..3.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  requester A access request; held until a_ack.
- a_we  in  1  A: 1 = write, 0 = read; valid while a_req is high.
- a_addr  in  ADDR_W  A access address.
- a_wdata  in  DATA_W  A write data.
- a_ack  out  1  one-cycle pulse: A's access was issued to the RAM this cycle.
- a_rvalid  out  1  one-cycle pulse: a_rdata holds A's read result.
- a_rdata  out  DATA_W  read data for A; equals ram_rd_data.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rvalid, b_rdata: same as the A ports, for requester B.
- ram_en  out  1  RAM enable (ena).
- ram_we  out  1  RAM write enable (wea).
- ram_addr  out  ADDR_W  RAM address (addra).
- ram_wr_data  out  DATA_W  RAM write data (dina).
- ram_rd_data  in  DATA_W  RAM read data (douta).

Behaviour:
- Reset (asynchronous, takes effect immediately on rst=1):
  - ram_en, ram_we, ram_addr, ram_wr_data = 0.
  - a_ack, b_ack, a_rvalid, b_rvalid = 0.
  - Round-robin pointer last_grant = B, so A wins the first contention.
  - Read-tracking pipeline cleared.
- Eligibility: a requester is eligible in cycle t if its req=1 and its ack=0 in cycle t. A request whose ack is showing is never re-granted.
- Arbitration (combinational in cycle t):
  - Only one eligible requester: grant it.
  - Both eligible: grant the one that is not last_grant.
  - None eligible: no grant.
- Issue (registered at the end of cycle t):
  - On grant, in cycle t+1:
    - ram_en=1.
    - ram_we = granted requester's we.
    - ram_addr and ram_wr_data = granted requester's addr and wdata.
    - Granted requester's ack=1.
    - last_grant updated to the granted requester.
  - No grant: ram_en=0 and ram_we=0; ram_addr and ram_wr_data hold their previous values.
  - ram_we is never 1 while ram_en=0.
- Requester protocol:
  - addr, we and wdata must be stable from req rise through the ack cycle.
  - In the ack cycle the requester may drop req or present a new request. A new request is eligible from the next cycle.
  - Sustained throughput: one access per 2 cycles per requester. Alternating A/B fills every cycle.
- Read return:
  - A read issued with ram_en=1 in cycle t+1 produces a rvalid pulse for the same requester in cycle t+1+RD_LAT.
  - Tracked by an RD_LAT-deep shift register of {valid, owner}.
  - Writes generate no rvalid.
  - a_rdata and b_rdata are continuous copies of ram_rd_data and are meaningful only while the matching rvalid=1.
  - a_rvalid and b_rvalid are mutually exclusive.
- Simultaneous events:
  - Both requests rising in the same cycle: A then B (pointer at reset), then alternate.
  - Returning rvalids and new issues overlap freely, since the RAM accepts one op per cycle.
- Read-after-write:
  - A write issued in cycle n, followed by a read of the same address issued in cycle n+1 or later, returns the written data (RAM write-first/no-change semantics are irrelevant to this ordering).
- Reset mid-operation:
  - In-flight reads are discarded; no rvalid is produced for them after reset.
  - Outstanding requests must be re-presented; they are eligible in the first cycle after rst falls.

Test Plan:
- Reset check: assert rst mid-stream -> all outputs 0 within the same cycle; no rvalid for an in-flight read; after release, A pending alone -> a_ack exactly 1 cycle after the first clock edge.
- Single write then read, A only, RD_LAT=1:
  - Write addr 5, data 0x3C -> ram_en=ram_we=1 and ram_addr=5 in the a_ack cycle.
  - Read addr 5 -> a_rvalid 1 cycle after its a_ack, a_rdata=0x3C.
  - b_ack and b_rvalid stay 0 throughout.
- Contention: A and B both request continuously.
  - Acks alternate A,B,A,B starting with A; ram_en=1 every cycle from the first issue.
  - No requester is acked in two consecutive cycles.
- Mixed traffic: A writes addr 0..31 with data = addr XOR 0xA5 while B reads addr 0..31 after all writes complete -> 32 b_rvalid pulses, in order, data matching; zero a_rvalid pulses.
- Latency sweep RD_LAT=1,2,3: single B read -> b_rvalid lands exactly RD_LAT cycles after ram_en for that read; reads interleaved with writes produce no spurious rvalid.
- Held request: A holds a_req with the same read for 4 cycles -> acked at cycles 1 and 3 (two accesses); a requester that drops a_req in its ack cycle gets exactly one access.
